// File: rtl/seq_verify.sv
// Sequence verifier: stores a five-digit sequence, then checks the player's
// entered digits one per button press and pulses correct or incorrect.
module seq_verify (
  input  logic        clk,
  input  logic        rst,
  input  logic        display_done,
  input  logic [2:0]  LVL,
  input  logic        b_player,
  input  logic        newSequence,
  input  logic [19:0] Sequence,
  input  logic [3:0]  player_num,
  output logic        correct,
  output logic        incorrect
);

  typedef enum logic [1:0] {
    StIdle,
    StLoaded,
    StCheck,
    StResult
  } state_e;

  state_e      state_q;
  logic [19:0] seq_q;
  logic [2:0]  idx_q;
  logic [2:0]  level_q;
  logic        b_prev_q;

  logic        press;
  logic [3:0]  cur_digit;
  logic [2:0]  eff_level;
  logic        last_digit;

  // Rising edge of the enter strobe; a held button yields a single press.
  always_comb begin
    press = b_player & ~b_prev_q;
  end

  // Select the stored digit addressed by the index; digit 0 is the top nibble.
  always_comb begin
    cur_digit = 4'h0;
    case (idx_q)
      3'd0:    cur_digit = seq_q[19:16];
      3'd1:    cur_digit = seq_q[15:12];
      3'd2:    cur_digit = seq_q[11:8];
      3'd3:    cur_digit = seq_q[7:4];
      3'd4:    cur_digit = seq_q[3:0];
      default: cur_digit = 4'h0;
    endcase
  end

  // Clamp the requested level into 1..5.
  always_comb begin
    eff_level = LVL;
    case (LVL)
      3'd0:       eff_level = 3'd1;
      3'd6, 3'd7: eff_level = 3'd5;
      default:    eff_level = LVL;
    endcase
    // level_q is at least 1 whenever CHECK is active.
    last_digit = (idx_q == (level_q - 3'd1));
  end

  // Main FSM with registered result pulses; newSequence overrides every
  // non-reset condition and restarts from LOADED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      seq_q     <= 20'h0;
      idx_q     <= 3'd0;
      level_q   <= 3'd0;
      b_prev_q  <= 1'b0;
      correct   <= 1'b0;
      incorrect <= 1'b0;
    end else begin
      b_prev_q  <= b_player;
      correct   <= 1'b0;
      incorrect <= 1'b0;
      if (newSequence) begin
        seq_q   <= Sequence;
        idx_q   <= 3'd0;
        state_q <= StLoaded;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StIdle;
          end
          StLoaded: begin
            if (display_done) begin
              level_q <= eff_level;
              idx_q   <= 3'd0;
              state_q <= StCheck;
            end
          end
          StCheck: begin
            if (press) begin
              if (player_num != cur_digit) begin
                incorrect <= 1'b1;
                state_q   <= StResult;
              end else if (last_digit) begin
                correct <= 1'b1;
                state_q <= StResult;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
          StResult: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_verify.sv
// Bench for seq_verify: a table of per-cycle input records with the outputs
// expected after that clock edge, checked through a scoreboard queue.
module tb_seq_verify;

  logic        clk;
  logic        rst;
  logic        display_done;
  logic [2:0]  LVL;
  logic        b_player;
  logic        newSequence;
  logic [19:0] Sequence;
  logic [3:0]  player_num;
  logic        correct;
  logic        incorrect;

  seq_verify dut (
    .clk          (clk),
    .rst          (rst),
    .display_done (display_done),
    .LVL          (LVL),
    .b_player     (b_player),
    .newSequence  (newSequence),
    .Sequence     (Sequence),
    .player_num   (player_num),
    .correct      (correct),
    .incorrect    (incorrect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ns;
    logic [19:0] seq;
    logic        dd;
    logic [2:0]  lvl;
    logic        bp;
    logic [3:0]  pn;
    logic        ec;
    logic        ei;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         done    = 1'b0;

  // Garbage on Sequence whenever newSequence is low; it must never be stored.
  localparam logic [19:0] Junk = 20'hF0F0F;

  function automatic void v(logic r, logic ns, logic [19:0] seq, logic dd, logic [2:0] lvl,
                            logic bp, logic [3:0] pn, logic ec, logic ei);
    vec_t t;
    t.rst = r; t.ns = ns; t.seq = seq; t.dd = dd; t.lvl = lvl;
    t.bp = bp; t.pn = pn; t.ec = ec; t.ei = ei;
    vecs.push_back(t);
  endfunction

  function automatic void idle();
    v(0, 0, Junk, 0, 3'd0, 0, 4'h0, 0, 0);
  endfunction

  function automatic void load(logic [19:0] s);
    v(0, 1, s, 0, 3'd0, 0, 4'h0, 0, 0);
  endfunction

  function automatic void go(logic [2:0] lvl);
    v(0, 0, Junk, 1, lvl, 0, 4'h0, 0, 0);
  endfunction

  // One press cycle followed by a release cycle (outputs always 0 there).
  function automatic void press(logic [3:0] d, logic ec, logic ei);
    v(0, 0, Junk, 0, 3'd0, 1, d, ec, ei);
    idle();
  endfunction

  task automatic check_out(input logic [1:0] exp_o, input string tag);
    n_tests++;
    if ({correct, incorrect} !== exp_o) begin
      n_fail++;
      $display("FAIL %s {correct,incorrect}: got %b%b expected %b", tag, correct, incorrect,
               exp_o);
    end
  endtask

  initial begin
    #200000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: bench did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    // Reset, then stray presses and display_done in IDLE do nothing.
    v(1, 0, Junk, 0, 3'd0, 0, 4'h0, 0, 0);
    press(4'h0, 0, 0);
    go(3'd3);
    press(4'h1, 0, 0);
    // Correct entry, LVL=3.
    load(20'h12345); go(3'd3);
    press(4'h1, 0, 0); press(4'h2, 0, 0); press(4'h3, 1, 0);
    // Wrong second digit, then a later press gives nothing.
    load(20'h12345); go(3'd3);
    press(4'h1, 0, 0); press(4'h1, 0, 1); press(4'h3, 0, 0); go(3'd3); press(4'h1, 0, 0);
    // Held button with changing digit while held must count once.
    load(20'h12345); go(3'd3);
    v(0, 0, Junk, 0, 3'd0, 1, 4'h1, 0, 0);
    v(0, 0, Junk, 0, 3'd0, 1, 4'h9, 0, 0);
    v(0, 0, Junk, 0, 3'd0, 1, 4'h9, 0, 0);
    v(0, 0, Junk, 0, 3'd0, 1, 4'h9, 0, 0);
    idle();
    press(4'h2, 0, 0); press(4'h3, 1, 0);
    // Level clamp: LVL=7 checks five digits, LVL=0 checks one.
    load(20'hABCDE); go(3'd7);
    press(4'hA, 0, 0); press(4'hB, 0, 0); press(4'hC, 0, 0); press(4'hD, 0, 0);
    press(4'hE, 1, 0);
    load(20'hABCDE); go(3'd0); press(4'hA, 1, 0);
    // Abort mid-check: newSequence beats a same-cycle press.
    load(20'h12345); go(3'd3); press(4'h1, 0, 0);
    v(0, 1, 20'h55555, 0, 3'd0, 1, 4'h2, 0, 0);
    idle();
    press(4'h5, 0, 0);                        // LOADED ignores presses
    go(3'd2);
    go(3'd5);                                 // ignored in CHECK, level stays 2
    press(4'h5, 0, 0); press(4'h5, 1, 0);
    // newSequence during RESULT restarts cleanly.
    load(20'h70000); go(3'd1);
    v(0, 0, Junk, 0, 3'd0, 1, 4'h7, 1, 0);
    v(0, 1, 20'h40000, 0, 3'd0, 0, 4'h0, 0, 0);
    go(3'd1); press(4'h4, 1, 0);
    // Reset beats a deciding press in CHECK; presses ignored afterwards.
    load(20'h12345); go(3'd1);
    v(1, 0, Junk, 0, 3'd0, 1, 4'h1, 0, 0);
    idle();
    press(4'h1, 0, 0); go(3'd1); press(4'h0, 0, 0); press(4'h1, 0, 0);
    // Reset cleared the stored sequence: reload and check the first digit.
    load(20'h30000); go(3'd1); press(4'h3, 1, 0);

    rst = 1'b1; newSequence = 1'b0; Sequence = 20'h0; display_done = 1'b0;
    LVL = 3'd0; b_player = 1'b0; player_num = 4'h0;

    @(posedge clk);
    #1;
    check_out(2'b00, "reset state");

    foreach (vecs[i]) begin
      logic [1:0] exp_o;
      @(negedge clk);
      rst          = vecs[i].rst;
      newSequence  = vecs[i].ns;
      Sequence     = vecs[i].seq;
      display_done = vecs[i].dd;
      LVL          = vecs[i].lvl;
      b_player     = vecs[i].bp;
      player_num   = vecs[i].pn;
      sb.push_back({vecs[i].ec, vecs[i].ei});
      @(posedge clk);
      #1;
      exp_o = sb.pop_front();
      check_out(exp_o, $sformatf("vec%0d", i));
    end

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
